// File: rtl/mem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_pkg
// Purpose  : Shared types and constants for the wait-stated memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package mem_resp_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage : mem_resp_pkg
`default_nettype wire

// File: rtl/word_ram.sv
`default_nettype none
// ============================================================================
// Module   : word_ram
// Purpose  : DEPTH x 32 word array, synchronous write, combinational read.
// Revision : 1.0 - initial release
// ============================================================================
module word_ram
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    // Contents are deliberately not reset.
    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : word_ram
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Single-outstanding word memory responder with WAIT_CYCLES wait
//            states and a one-cycle ack. Define MEM_RESP_RANGE_CHK_EN to flag
//            out-of-range word indices with err instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [WORD_W-1:0] adr,
    input  logic [WORD_W-1:0] wd,
    output logic [WORD_W-1:0] rd,
    output logic              ack,
    output logic              busy,
    output logic              err
);

    localparam int AW        = $clog2(DEPTH);
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic              oor_q;
    logic [AW-1:0]     idx_q;
    logic [WORD_W-1:0] wd_q;
    logic [WORD_W-1:0] rd_q;
    logic              ack_q;
    logic              busy_q;
    logic              err_q;

    logic [AW-1:0]     w_adr_idx;
    logic              w_adr_oor;
    logic              w_in_idle;
    logic              w_accept;
    logic              w_enter_resp;
    logic [AW-1:0]     w_cur_idx;
    logic              w_cur_oor;
    logic              w_cur_we;
    logic              w_ram_we;
    logic [WORD_W-1:0] w_ram_rd;
    logic              w_unused;

    assign w_adr_idx = adr[AW+1:2];

`ifdef MEM_RESP_RANGE_CHK_EN
    assign w_adr_oor = |adr[WORD_W-1:AW+2];
    assign w_unused  = ^adr[1:0];
`else
    assign w_adr_oor = 1'b0;
    assign w_unused  = ^{adr[1:0], adr[WORD_W-1:AW+2]};
`endif

    assign w_in_idle    = (state_q == ST_IDLE);
    assign w_accept     = w_in_idle && req;
    assign w_enter_resp = (w_accept && ZERO_WAIT) ||
                          ((state_q == ST_WAIT) && (cnt_q == CNT_W'(1)));

    // With zero wait states the read happens on the accept edge, before the
    // holding registers are loaded, so the live bus is used in IDLE.
    assign w_cur_idx = w_in_idle ? w_adr_idx : idx_q;
    assign w_cur_oor = w_in_idle ? w_adr_oor : oor_q;
    assign w_cur_we  = w_in_idle ? we        : we_q;

    assign w_ram_we  = (state_q == ST_RESP) && we_q && !oor_q;

    word_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_word_ram (
        .clk     (clk),
        .we_i    (w_ram_we),
        .waddr_i (idx_q),
        .wdata_i (wd_q),
        .raddr_i (w_cur_idx),
        .rdata_o (w_ram_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            idx_q   <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        idx_q   <= w_adr_idx;
                        wd_q    <= wd;
                        oor_q   <= w_adr_oor;
                        cnt_q   <= CNT_W'(WAIT_CYCLES);
                        busy_q  <= 1'b1;
                        state_q <= ZERO_WAIT ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (w_enter_resp) begin
                ack_q <= 1'b1;
                err_q <= w_cur_oor;
                if (!w_cur_we) begin
                    rd_q <= w_cur_oor ? '0 : w_ram_rd;
                end
            end
        end
    end

    assign rd   = rd_q;
    assign ack  = ack_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule : mem_responder
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Scoreboard bench for mem_responder (WAIT_CYCLES=2 and =0 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int DEPTH = 64;
    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we, ack, busy, err;
    logic [31:0] adr, wd, rd;
    logic        req0, we0, ack0, busy0, err0;
    logic [31:0] adr0, wd0, rd0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .adr(adr), .wd(wd),
        .rd(rd), .ack(ack), .busy(busy), .err(err)
    );

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .adr(adr0), .wd(wd0),
        .rd(rd0), .ack(ack0), .busy(busy0), .err(err0)
    );

    typedef struct {
        logic        is_rd;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Exactly one transaction is outstanding whenever ack fires.
    always @(negedge clk) begin
        if (!reset && ack) begin
            exp_t e;
            check_eq("sb_depth_at_ack", 32'(sb_q.size()), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_eq("ack_err", 32'(err), 32'(e.err));
                if (e.is_rd) check_eq("read_data", rd, e.rd);
            end
        end
    end

    // Called #1 after a rising edge with the DUT in IDLE.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input bit hold, input bit chg, input bit abort_it);
        int lat;
        req = 1'b1; we = w; adr = a; wd = d;
        if (!abort_it) sb_q.push_back('{is_rd: !w, rd: exp_rd, err: exp_err});
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        if (chg) begin adr = a + 32'd4; wd = 32'h0; end
        check_eq("busy_after_accept", 32'(busy), 32'd1);
        if (abort_it) begin
            reset = 1'b1;
            #1;
            check_eq("abort_outputs", {rd[28:0], ack, busy, err}, 32'h0);
            check_eq("abort_rd", rd, 32'h0);
            @(posedge clk); #1;
            reset = 1'b0; req = 1'b0;
            repeat (WAITC + 3) @(posedge clk);
            #1;
            return;
        end
        lat = 1;
        while (!ack && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("ack_latency", 32'(lat), 32'(WAITC + 1));
        req = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_after_ack", 32'({busy, ack}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        req = 1'b0; we = 1'b0; adr = '0; wd = '0;
        req0 = 1'b0; we0 = 1'b0; adr0 = '0; wd0 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_outputs", 32'({ack, busy, err, ack0, busy0, err0}), 32'd0);
        check_eq("rst_rd", rd, 32'h0);
        check_eq("rst_rd0", rd0, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Write then read back
        txn(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0, 0, 0);
        txn(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, 0, 0);

        // Known background values
        txn(1'b1, 32'h24, 32'h7777, 32'h0, 1'b0, 0, 0, 0);
        txn(1'b1, 32'h08, 32'h5555, 32'h0, 1'b0, 0, 0, 0);
        txn(1'b1, 32'h00, 32'h11,   32'h0, 1'b0, 0, 0, 0);

        // Bus changes during WAIT have no effect
        txn(1'b1, 32'h20, 32'h1234, 32'h0, 1'b0, 0, 1, 0);
        txn(1'b0, 32'h20, 32'h0, 32'h1234, 1'b0, 0, 0, 0);
        txn(1'b0, 32'h24, 32'h0, 32'h7777, 1'b0, 0, 0, 0);

        // Reset during WAIT aborts the write
        txn(1'b1, 32'h08, 32'hFFFF, 32'h0, 1'b0, 0, 0, 1);
        txn(1'b0, 32'h08, 32'h0, 32'h5555, 1'b0, 0, 0, 0);

        // Out-of-range index
`ifdef MEM_RESP_RANGE_CHK_EN
        txn(1'b1, 32'h100, 32'hAA, 32'h0, 1'b1, 0, 0, 0);
        txn(1'b0, 32'h100, 32'h0,  32'h0, 1'b1, 0, 0, 0);
        txn(1'b0, 32'h000, 32'h0,  32'h11, 1'b0, 0, 0, 0);
`else
        txn(1'b1, 32'h100, 32'hAA, 32'h0,  1'b0, 0, 0, 0);
        txn(1'b0, 32'h100, 32'h0,  32'hAA, 1'b0, 0, 0, 0);
        txn(1'b0, 32'h000, 32'h0,  32'hAA, 1'b0, 0, 0, 0);
`endif

        // req held high while busy yields a single ack
        txn(1'b1, 32'h30, 32'hBEEF, 32'h0, 1'b0, 1, 0, 0);
        txn(1'b0, 32'h30, 32'h0, 32'hBEEF, 1'b0, 0, 0, 0);

        // Zero-wait instance: ack next cycle, then reads every 2 cycles
        req0 = 1'b1; we0 = 1'b1; adr0 = 32'h0; wd0 = 32'hCAFE;
        @(posedge clk); #1;
        check_eq("zw_ack_latency", 32'(ack0), 32'd1);
        check_eq("zw_busy", 32'(busy0), 32'd1);
        we0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_eq("zw_ack_pattern", 32'(ack0), 32'(i % 2));
            if (ack0) begin
                check_eq("zw_read_data", rd0, 32'hCAFE);
                check_eq("zw_err", 32'(err0), 32'd0);
            end
        end
        req0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_responder
`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Wait-stated memory responder serving the processor's data/instruction memory bus. It accepts one word request at a time (read or write), inserts a configurable number of wait states, then completes the request with a one-cycle acknowledge. It sits between the core's `adr`/`writedata`/`memwrite` bus and a word-addressed RAM, and is the responder side for a stall-capable core.

## Interface
- `DEPTH`, 64: number of 32-bit words; must be a power of two, at least 2.
- `WAIT_CYCLES`, 2: wait states inserted before acknowledge; 0 to 15.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in 1: request valid; held with `we`/`adr`/`wd` stable until `ack`.
- `we` in 1: 1 = write, 0 = read.
- `adr` in 32: byte address; `adr[1:0]` ignored.
- `wd` in 32: write data.
- `rd` out 32: read data, registered, valid in the `ack` cycle of a read and held until the next read `ack`.
- `ack` out 1: single-cycle completion pulse.
- `busy` out 1: high in WAIT and RESP.
- `err` out 1: out-of-range flag, valid with `ack`.

## Operation
- State machine: IDLE, WAIT, RESP.
- IDLE:
  - If `req`=1, capture `we`, word index `adr[31:2]` and `wd` into holding registers.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT, or to RESP directly if `WAIT_CYCLES`=0.
- WAIT: decrement the counter each cycle; when it equals 1, go to RESP.
- RESP:
  - `ack`=1 for exactly one cycle, then return to IDLE.
  - Write: RAM updated at the edge ending the RESP cycle.
  - Read: `rd` loaded from the RAM on the edge entering RESP.
- `req` is ignored outside IDLE. Changes to `adr`/`wd`/`we` after capture have no effect.
- Index is `adr[AW+1:2]`, where AW = log2(DEPTH).
- Reset values: state IDLE, `ack`=0, `busy`=0, `err`=0, `rd`=0, counter 0.
- RAM contents are not cleared by reset.
- Reset asserted mid-transaction:
  - The transaction is aborted and no write occurs.
  - No `ack` is produced.

## Timing
- `req` sampled high in IDLE at cycle t gives `ack` in cycle t+WAIT_CYCLES+1.
- `busy` is high from cycle t+1 through the `ack` cycle.
- Earliest next acceptance is cycle t+WAIT_CYCLES+2. Throughput is one transaction per WAIT_CYCLES+2 cycles.
- Read-after-write to the same address in back-to-back transactions returns the new data.
- No combinational path from any input to `ack`, `busy`, `rd` or `err`.

## Configuration
- `MEM_RESP_RANGE_CHK_EN` defined:
  - Any word index `adr[31:2]` ≥ DEPTH completes normally in timing, with `err`=1 in the `ack` cycle.
  - Writes are suppressed and `rd` is 0.
- Not defined:
  - Addresses wrap modulo DEPTH using the low AW index bits.
  - `err` is tied to 0. The port remains present.

## Structure
- Shared package `mem_resp_pkg` holds:
  - the state encoding typedef (IDLE/WAIT/RESP);
  - the `WORD_W` = 32 constant;
  - the counter width constant (4).
- One sub-module, `word_ram`:
  - DEPTH×32 array, synchronous write, combinational read;
  - instantiated once and driven from the holding registers.
- FSM, counter, holding registers and range check live in `mem_responder`.

## Test plan
- Write then read, with WAIT_CYCLES=2: write `adr`=0x10, `wd`=0xDEADBEEF, then read 0x10.
  - `ack` appears 3 cycles after each accept.
  - The read returns `rd`=0xDEADBEEF.
- Zero-wait build, with WAIT_CYCLES=0: read 0x0.
  - `ack` appears in the next cycle.
  - Back-to-back reads complete every 2 cycles.
- Mid-transaction input change: change `adr` from 0x20 to 0x24 and `wd` to 0x0 during WAIT of a write of 0x1234 to 0x20.
  - Word 0x20 = 0x1234; word 0x24 unchanged.
- Reset during transaction: assert `reset` during WAIT of a write of 0xFFFF to 0x8.
  - Outputs go to 0 immediately.
  - No `ack`; word 0x8 unchanged.
- Out-of-range access with `MEM_RESP_RANGE_CHK_EN`: write 0xAA to 0x100, then read 0x100.
  - `ack` with `err`=1 for both; `rd`=0.
  - Word 0 unchanged.
  - Without the macro, word 0 becomes 0xAA and `err`=0.
- Ignored request: assert `req` while `busy`=1.
  - No extra `ack`; exactly one `ack` per accepted request.
